// File: rtl/rr_sched_pkg.sv
// Shared constants and state encoding for the round-robin grant scheduler.
package rr_sched_pkg;

  localparam int N_REQ        = 8;
  localparam int IDX_W        = 3;
  localparam int MAX_HOLD_DEF = 255;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/rr_onehot_dec.sv
// 3-to-8 one-hot decoder feeding the registered grant vector.
module rr_onehot_dec
  import rr_sched_pkg::*;
(
  input  logic             i_en,
  input  logic [IDX_W-1:0] i_idx,
  output logic [N_REQ-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_idx] = 1'b1;
  end

endmodule

// File: rtl/rr_grant_sched.sv
// Round-robin owner scheduler for one shared 8-way resource.
// Optional hold-limit preemption is enabled by defining GRANT_TIMEOUT_EN.
module rr_grant_sched
  import rr_sched_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld,
  output logic             timeout
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD out of range 1..255");
  end

  // Rotate so last+1 sits at bit 0, find lowest set bit, map back.
  function automatic logic [IDX_W:0] f_rr_pick(
    input logic [N_REQ-1:0] v,
    input logic [IDX_W-1:0] last
  );
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W:0]     s;
    logic [IDX_W-1:0]   j;
    logic               hit;
    dbl = {v, v};
    s   = {1'b0, last} + 4'd1;
    rot = dbl[s +: N_REQ];
    j   = '0;
    hit = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        j   = IDX_W'(k);
        hit = 1'b1;
      end
    end
    return {hit, last + j + 3'd1};
  endfunction

  state_e           r_state;
  state_e           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_last;
  logic [N_REQ-1:0] r_grant;
  logic             r_to;

  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_vld_nxt;
  logic             w_new;
  logic             w_to_nxt;
  logic [N_REQ-1:0] w_own;
  logic [N_REQ-1:0] w_mask;
  logic [N_REQ-1:0] w_dec;
  logic             w_hit;
  logic [IDX_W-1:0] w_win;
  logic             w_hold;

  assign w_own  = N_REQ'(1) << r_idx;
  assign w_hold = |(req & w_own);
  assign w_mask = (r_state == ST_BUSY) ? (req & ~w_own) : req;
  assign {w_hit, w_win} = f_rr_pick(w_mask, r_last);

`ifdef GRANT_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);
  logic [7:0] r_cnt;
  logic       w_expire;

  assign w_expire = (r_cnt >= HOLD_LIM) && w_hit;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_vld_nxt   = (r_state == ST_BUSY);
    w_new       = 1'b0;
    w_to_nxt    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_hit) begin
          w_state_nxt = ST_BUSY;
          w_idx_nxt   = w_win;
          w_vld_nxt   = 1'b1;
          w_new       = 1'b1;
        end
      end
      ST_BUSY: begin
        if (!w_hold) begin
          if (w_hit) begin
            w_idx_nxt = w_win;
            w_new     = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
            w_vld_nxt   = 1'b0;
          end
        end
`ifdef GRANT_TIMEOUT_EN
        else if (w_expire) begin
          w_idx_nxt = w_win;
          w_new     = 1'b1;
          w_to_nxt  = 1'b1;
        end
`endif
      end
    endcase
  end

  rr_onehot_dec u_dec (
    .i_en     (w_vld_nxt),
    .i_idx    (w_idx_nxt),
    .o_onehot (w_dec)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_last  <= 3'd7;
      r_grant <= '0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_grant <= w_dec;
      r_to    <= w_to_nxt;
      if (w_new) r_last <= w_idx_nxt;
    end
  end

`ifdef GRANT_TIMEOUT_EN
  // Saturates at the limit so a late rival is preempted-for at once.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cnt <= '0;
    end else if (w_new) begin
      r_cnt <= '0;
    end else if (r_state == ST_BUSY && w_hold && r_cnt < HOLD_LIM) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end
`endif

  assign grant     = r_grant;
  assign grant_idx = r_idx;
  assign grant_vld = |r_grant;
  assign timeout   = r_to;

endmodule

// File: tb/tb_rr_grant_sched.sv
// Randomized and directed checks of rr_grant_sched against a queue-free
// behavioural owner/pointer model.
module tb_rr_grant_sched;

  localparam int MAXH = 4;

  logic       Clk;
  logic       Reset_n;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_vld;
  logic       timeout;

  int n_chk;
  int n_err;

  int m_own;
  int m_last;
  int m_cnt;
  int m_to;

  int held;
  int order[$];

  rr_grant_sched #(.MAX_HOLD(MAXH)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .req       (req),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld),
    .timeout   (timeout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [7:0] v, input int last);
    for (int k = 1; k <= 8; k++) begin
      int i;
      i = (last + k) % 8;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_own  = -1;
    m_last = 7;
    m_cnt  = 0;
    m_to   = 0;
  endtask

  task automatic m_take(input int w, input int to);
    m_own  = w;
    m_last = w;
    m_cnt  = 0;
    m_to   = to;
  endtask

  task automatic m_step(input logic [7:0] r);
    logic [7:0] others;
    int w;
    m_to = 0;
    if (m_own < 0) begin
      w = pick(r, m_last);
      if (w >= 0) m_take(w, 0);
    end else begin
      others = r;
      others[m_own] = 1'b0;
      w = pick(others, m_own);
      if (!r[m_own]) begin
        if (w >= 0) m_take(w, 0);
        else m_own = -1;
      end else begin
`ifdef GRANT_TIMEOUT_EN
        if (m_cnt >= MAXH - 1 && w >= 0) m_take(w, 1);
        else if (m_cnt < MAXH - 1) m_cnt++;
`endif
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [7:0] eg;
    eg = (m_own >= 0) ? (8'h01 << m_own) : 8'h00;
    chk({tag, ".grant"}, 32'(grant), 32'(eg));
    chk({tag, ".idx"}, 32'(grant_idx), (m_own >= 0) ? m_own : 0);
    chk({tag, ".vld"}, 32'(grant_vld), (m_own >= 0) ? 1 : 0);
    chk({tag, ".to"}, 32'(timeout), 32'(m_to));
  endtask

  task automatic cyc(input logic [7:0] r, input string tag);
    int prev;
    prev = m_own;
    req = r;
    @(posedge Clk);
    m_step(r);
    #1;
    check_model(tag);
    if (m_own >= 0 && m_own == prev) held++;
    else held = 1;
    if (m_own >= 0 && m_own != prev) order.push_back(m_own);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    m_reset();
    #1;
    check_model("rst");
    @(negedge Clk);
    Reset_n = 1'b1;
    held = 0;
  endtask

  initial begin
    logic [7:0] r;
    n_chk   = 0;
    n_err   = 0;
    req     = 8'h00;
    Reset_n = 1'b0;
    m_reset();
    #12;
    chk("rst.grant", 32'(grant), 0);
    chk("rst.idx", 32'(grant_idx), 0);
    chk("rst.vld", 32'(grant_vld), 0);
    chk("rst.to", 32'(timeout), 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      cyc(8'h00, "idle");
      chk("idle.g", 32'(grant), 0);
    end

    cyc(8'h81, "t2a");
    chk("t2a.g", 32'(grant), 32'h01);
    cyc(8'h80, "t2b");
    chk("t2b.g", 32'(grant), 32'h80);
    chk("t2b.i", 32'(grant_idx), 7);
    cyc(8'h00, "t2c");
    chk("t2c.g", 32'(grant), 32'h00);

    do_reset();
    order.delete();
    for (int c = 0; c < 40; c++) begin
      r = 8'hFF;
      if (m_own >= 0 && held >= 2) r[m_own] = 1'b0;
      cyc(r, "rrff");
    end
    chk("rrff.len", 32'(order.size() >= 9), 1);
    for (int k = 0; k < 9 && k < order.size(); k++)
      chk("rrff.ord", 32'(order[k]), 32'(k % 8));

    do_reset();
    cyc(8'h08, "own3");
    chk("own3.g", 32'(grant), 32'h08);
    #2;
    Reset_n = 1'b0;
    m_reset();
    #1;
    chk("arst.g", 32'(grant), 0);
    chk("arst.v", 32'(grant_vld), 0);
    chk("arst.t", 32'(timeout), 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    cyc(8'h08, "rel3");
    chk("rel3.g", 32'(grant), 32'h08);
    chk("rel3.i", 32'(grant_idx), 3);

`ifdef GRANT_TIMEOUT_EN
    do_reset();
    for (int c = 0; c < 14; c++) begin
      cyc(8'h06, "to06");
      chk("to06.g", 32'(grant), ((c / MAXH) % 2 == 0) ? 32'h02 : 32'h04);
      chk("to06.p", 32'(timeout), (c >= MAXH && c % MAXH == 0) ? 1 : 0);
    end
    do_reset();
    for (int c = 0; c < 20; c++) begin
      cyc(8'h02, "solo");
      chk("solo.g", 32'(grant), 32'h02);
      chk("solo.p", 32'(timeout), 0);
    end
`endif

    do_reset();
    for (int c = 0; c < 400; c++) begin
      r = 8'($urandom);
      if ($urandom % 8 == 0) r = 8'h00;
      if (m_own >= 0 && ($urandom % 4 != 0)) r[m_own] = 1'b1;
      cyc(r, "rand");
      chk("rand.1h", 32'($countones(grant) <= 1), 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rr_grant_sched.md
# rr_grant_sched

Round-robin scheduler that shares one 8-way resource among eight requesters and drives its select lines. Each cycle it holds at most one owner, presented both as a registered 3-bit index and as the matching 8-bit one-hot grant (3-to-8 decode of the index). It sits between the request sources and the shared 8-way output datapath, whose select it owns.

## Interface
- MAX_HOLD, 255: grant-timeout limit in cycles; legal range 1..255; only used with GRANT_TIMEOUT_EN.
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- req  input  8  request per requester; level-sensitive; the owner keeps its bit high while it uses the resource.
- grant  output  8  one-hot grant; all zero when no owner.
- grant_idx  output  3  index of the owner; 3'd0 when no owner.
- grant_vld  output  1  high while an owner exists.
- timeout  output  1  one-cycle pulse when an owner is preempted; tied 0 without GRANT_TIMEOUT_EN.

## Operation
- Two states, held in a registered FSM:
  - IDLE: no owner.
  - BUSY: one owner holds the resource.
- Round-robin pointer last_idx (3 bits) records the index of the most recent grant.
- Search order: last_idx+1, last_idx+2, … last_idx+8, computed modulo 8 (wraps 7→0).
- IDLE:
  - If req != 0, grant the first set bit in search order and go to BUSY.
  - Update last_idx to the granted index.
- BUSY, owner's req still high: hold the grant; the timeout rule may apply.
- BUSY, owner's req low (release):
  - Re-arbitrate the same cycle over the remaining req bits, excluding the owner, in search order from the owner+1.
  - If a winner exists, hand over back-to-back and stay in BUSY.
  - Otherwise go to IDLE.
- Fairness: a requester granted at index k is searched last in the next arbitration.
- Outputs are registered:
  - grant is the registered decode of grant_idx, never combinational from req.
  - grant always has at most one bit set.
  - grant_vld == |grant.
- req bits of non-owners may toggle freely in BUSY; they have no effect until an arbitration point.

## Timing
- Reset values:
  - grant = 8'h00, grant_idx = 3'd0, grant_vld = 0, timeout = 0.
  - state = IDLE, last_idx = 3'd7, so the first search starts at 0.
  - Hold counter = 0.
- Grant latency: a req rising in IDLE, sampled at edge t, gives grant valid after edge t (one cycle from request to grant).
- Handover: owner req low sampled at edge t → new owner visible after edge t, with no idle gap.
- Release with no other requester: grant_vld low after edge t.
- Simultaneous requests: resolved purely by search order; ties are impossible.
- Owner's req low and another requester rising in the same cycle: the new requester is eligible at that edge.
- Reset asserted mid-grant: all outputs clear immediately (asynchronous), pointer returns to 7, no timeout pulse.
- Deassertion of Reset_n must be synchronized externally to Clk.

## Configuration
- GRANT_TIMEOUT_EN defined:
  - An 8-bit hold counter clears on every new grant and increments each BUSY cycle while the owner holds.
  - When the counter reaches MAX_HOLD−1 and another req bit is set, the next edge forces a handover to the next requester in search order.
  - timeout pulses high for that single cycle.
  - The counter saturates when the owner is the only requester; in that case there is no preemption.
- GRANT_TIMEOUT_EN undefined:
  - No counter is instantiated; the owner holds indefinitely.
  - timeout is constant 0.

## Structure
- Shared package rr_sched_pkg holds:
  - N_REQ = 8, IDX_W = 3.
  - State encoding constants ST_IDLE = 1'b0, ST_BUSY = 1'b1.
  - MAX_HOLD default.
- Sub-module rr_onehot_dec is a combinational 3-to-8 decoder from the next-index value. Its output is registered into grant by the parent, keeping the one-hot output and the index in lockstep.
- The round-robin search is one combinational function (rotate, priority-find, un-rotate) inside the parent.

## Test plan
- Reset, then req = 8'h00 for 5 cycles → grant = 8'h00, grant_vld = 0, grant_idx = 0 throughout.
- From reset, req = 8'h81 → after 1 edge grant = 8'h01, idx = 0; drop req[0] → next edge grant = 8'h80, idx = 7; drop req[7] → grant = 8'h00 next edge.
- req = 8'hFF held; each owner releases for one cycle after 2 cycles of ownership → grant order 0,1,2,…,7,0 with no idle cycles between owners.
- Owner idx 3, Reset_n pulsed low mid-cycle → grant = 0 asynchronously; after release with req = 8'h08, grant = 8'h08 after the first edge.
- GRANT_TIMEOUT_EN, MAX_HOLD = 4, req = 8'h06 held, no release → grant 8'h02 for 4 cycles, timeout pulse, then 8'h04 for 4 cycles, timeout, then 8'h02 again.
- GRANT_TIMEOUT_EN, MAX_HOLD = 4, req = 8'h02 alone for 20 cycles → grant stays 8'h02, timeout never asserts.
